rom_table_streamer: RTL and testbench
=====================================

// Module: rom_table_streamer
// PURPOSE
//  Consumes the 8-entry x 4-bit parallel table produced by the reset-initialised ROM block.
//  On a start command it snapshots the table, then streams a burst of entries out over a
//  valid/ready interface, beginning at a programmable index and wrapping modulo DEPTH.
//  It also accumulates the sum of the delivered beats.
//  Sits directly downstream of the ROM and feeds any serial consumer: DAC model, checker, UART.
// PARAMETERS
//  DEPTH  8  number of table entries (power of two)
//  DW     4  width of one table entry
//  AW     3  index width, equal to log2(DEPTH)
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         reset, asynchronous, active-low
//  tbl_i        in   DEPTH*DW  flattened table; entry k = tbl_i[k*DW +: DW]
//  start_i      in   1         start request (level sampled each cycle)
//  start_idx_i  in   AW        first entry index of the burst
//  len_i        in   AW+1      burst length, 1..DEPTH; 0 = invalid
//  out_valid_o  out  1         output beat valid
//  out_ready_i  in   1         downstream ready
//  out_data_o   out  DW        entry value
//  out_idx_o    out  AW        table index of current beat
//  out_last_o   out  1         final beat of burst
//  busy_o       out  1         high in STREAM and DONE states
//  done_o       out  1         one-cycle pulse after last beat accepted
//  sum_o        out  DW+AW     sum of beats delivered in current/last burst
// BEHAVIOUR
//  Reset (async assert): state=IDLE; all outputs 0; snapshot regs 0; sum_o=0.
//   Reset deasserts synchronously to clk.
//  FSM IDLE -> STREAM -> DONE -> IDLE.
//  IDLE: start accepted when start_i=1 && len_i!=0.
//   - On accept: snapshot tbl_i; latch idx=start_idx_i, rem=len_i; clear sum_o.
//   - First beat loaded into output register, so out_valid_o=1 the cycle after accept.
//   - len_i=0 with start_i=1: ignored, stay IDLE.
//  STREAM: out_data_o = snapshot[idx]; out_last_o = (rem==1).
//   - Data, idx and last held stable while out_valid_o && !out_ready_i.
//   - Handshake (valid && ready) on an edge: sum_o += out_data_o.
//     - If last: out_valid_o=0, go to DONE.
//     - Else: idx=(idx+1) mod DEPTH, rem-=1, next beat presented next cycle.
//   - Throughput is 1 beat/cycle with ready held high.
//  DONE: done_o=1 for exactly one cycle, then IDLE.
//   - sum_o holds final value until the next accepted start.
//  start_i in STREAM or DONE is ignored; no queuing.
//  Wrap-around: index DEPTH-1 is followed by 0. A len=DEPTH burst returns every entry exactly once.
//  tbl_i changes after accept do not affect the burst in progress (snapshot only).
//  Arithmetic: sum_o is unsigned and never overflows (max DEPTH*(2^DW-1) = 120).
//  Reset mid-burst: immediate abort; outputs 0; next start after release behaves normally.
// TESTING  (tbl_i = ROM reset content 0,2,4,...,14)
//  1. start idx=0 len=8, ready=1 -> data 0,2,...,14 on 8 consecutive cycles.
//     last with 14; done pulse next cycle; sum_o=56.
//  2. start idx=6 len=4 -> data 12,14,0,2 with idx 6,7,0,1; last on idx 1; sum_o=28.
//  3. idx=0 len=3, ready toggling 1/0 -> each beat held stable while !ready.
//     Exactly 3 handshakes; sum_o=6.
//  4. start pulsed mid-burst -> ignored, original burst unchanged.
//     start with len=0 -> busy_o stays 0, no valid.
//  5. tbl_i forced to all 4'hF after accept of idx=0 len=8 -> output still 0..14.
//  6. rst_n low during beat 3 of len=8 -> outputs 0 immediately.
//     After release, start idx=2 len=2 -> data 4,6; sum_o=10.

Source files
------------

// File: rtl/rom_table_streamer.sv
// rom_table_streamer
// Snapshots an 8 x 4-bit parallel ROM table on a start command and streams a burst of
// entries over valid/ready, starting at a programmable index and wrapping modulo DEPTH.
// The sum of all delivered beats is accumulated alongside the burst.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   tbl_i        flattened table, entry k = tbl_i[k*DW +: DW]
//   start_i      start request, level sampled each cycle
//   start_idx_i  first entry index of the burst
//   len_i        burst length 1..DEPTH, 0 is ignored
//   out_valid_o  output beat valid
//   out_ready_i  downstream ready
//   out_data_o   entry value of the current beat
//   out_idx_o    table index of the current beat
//   out_last_o   final beat of the burst
//   busy_o       high while streaming or finishing
//   done_o       one-cycle pulse after the last beat is accepted
//   sum_o        sum of the beats delivered in the current/last burst
module rom_table_streamer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 4,
  parameter int unsigned AW    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DEPTH*DW-1:0] tbl_i,
  input  logic                start_i,
  input  logic [AW-1:0]       start_idx_i,
  input  logic [AW:0]         len_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DW-1:0]       out_data_o,
  output logic [AW-1:0]       out_idx_o,
  output logic                out_last_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [DW+AW-1:0]    sum_o
);

  localparam int unsigned SW = DW + AW;

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e              state_q, state_d;
  logic [DEPTH*DW-1:0] snap_q, snap_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [AW:0]         rem_q, rem_d;
  logic                valid_q, valid_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic [DW-1:0]       cur_data;
  logic                is_last;

  // Beat data comes straight from the snapshot, so later tbl_i changes cannot leak in.
  assign cur_data = snap_q[DW*idx_q +: DW];
  assign is_last  = (rem_q == (AW+1)'(1));

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && (len_i != '0)) begin
          snap_d  = tbl_i;
          idx_d   = start_idx_i;
          rem_d   = len_i;
          sum_d   = '0;
          valid_d = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        if (valid_q && out_ready_i) begin
          sum_d = sum_q + {{AW{1'b0}}, cur_data};
          if (is_last) begin
            valid_d = 1'b0;
            state_d = StDone;
          end else begin
            // DEPTH is a power of two, so natural AW-bit overflow is the wrap.
            idx_d = idx_q + 1'b1;
            rem_d = rem_q - 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      snap_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = cur_data;
  assign out_idx_o   = idx_q;
  assign out_last_o  = valid_q && is_last;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign sum_o       = sum_q;

endmodule

// File: tb/tb_rom_table_streamer.sv
// Directed self-checking bench for rom_table_streamer using the ROM reset table 0,2,...,14.
module tb_rom_table_streamer;

  logic        clk;
  logic        rst_n;
  logic [31:0] tbl_i;
  logic        start_i;
  logic [2:0]  start_idx_i;
  logic [3:0]  len_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  out_data_o;
  logic [2:0]  out_idx_o;
  logic        out_last_o;
  logic        busy_o;
  logic        done_o;
  logic [6:0]  sum_o;

  int n_vec = 0;
  int n_err = 0;

  rom_table_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tbl_i       (tbl_i),
    .start_i     (start_i),
    .start_idx_i (start_idx_i),
    .len_i       (len_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_idx_o   (out_idx_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sum_o       (sum_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rom_tbl();
    logic [31:0] t;
    for (int k = 0; k < 8; k++) t[k*4 +: 4] = 4'(2 * k);
    return t;
  endfunction

  // Issue a start, then follow the burst beat by beat against the ROM model (entry k = 2k).
  task automatic run_burst(input logic [2:0] sidx, input logic [3:0] len, input bit toggle,
                           input bit poke_start, input bit poke_tbl, input logic [6:0] exp_sum);
    int beat = 0;
    int cycles = 0;
    bit poked = 1'b0;
    logic [2:0] ei;
    @(negedge clk);
    out_ready_i = 1'b1;
    start_i     = 1'b1;
    start_idx_i = sidx;
    len_i       = len;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("valid_after_accept", 32'(out_valid_o), 32'd1);
    if (poke_tbl) tbl_i = 32'hFFFF_FFFF;
    while (beat < int'(len) && cycles < 64) begin
      @(negedge clk);
      if (poked) start_i = 1'b0;
      out_ready_i = toggle ? (cycles % 2 == 0) : 1'b1;
      if (poke_start && beat == 2 && !poked) begin
        start_i     = 1'b1;
        start_idx_i = 3'd5;
        len_i       = 4'd1;
        poked       = 1'b1;
      end
      ei = 3'((int'(sidx) + beat) % 8);
      chk("beat_valid", 32'(out_valid_o), 32'd1);
      chk("beat_data", 32'(out_data_o), 32'(2 * int'(ei)));
      chk("beat_idx", 32'(out_idx_o), 32'(ei));
      chk("beat_last", 32'(out_last_o), 32'(beat == int'(len) - 1));
      if (out_valid_o && out_ready_i) beat++;
      cycles++;
    end
    chk("burst_complete", 32'(beat), 32'(len));
    if (!toggle) chk("burst_cycles", 32'(cycles), 32'(len));
    @(negedge clk);
    start_i = 1'b0;
    out_ready_i = 1'b1;
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("done_valid", 32'(out_valid_o), 32'd0);
    chk("sum", 32'(sum_o), 32'(exp_sum));
    @(negedge clk);
    chk("done_cleared", 32'(done_o), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("sum_held", 32'(sum_o), 32'(exp_sum));
    tbl_i = rom_tbl();
  endtask

  initial begin
    rst_n       = 1'b0;
    tbl_i       = rom_tbl();
    start_i     = 1'b0;
    start_idx_i = '0;
    len_i       = '0;
    out_ready_i = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_sum", 32'(sum_o), 32'd0);
    chk("rst_data", 32'(out_data_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_burst(3'd0, 4'd8, 1'b0, 1'b0, 1'b0, 7'd56);  // full table
    run_burst(3'd6, 4'd4, 1'b0, 1'b0, 1'b0, 7'd28);  // wrap-around
    run_burst(3'd0, 4'd3, 1'b1, 1'b0, 1'b0, 7'd6);   // backpressure
    run_burst(3'd0, 4'd8, 1'b0, 1'b1, 1'b0, 7'd56);  // start mid-burst ignored

    // len=0 start is ignored
    @(negedge clk);
    start_i = 1'b1;
    len_i   = 4'd0;
    @(negedge clk);
    chk("len0_busy", 32'(busy_o), 32'd0);
    chk("len0_valid", 32'(out_valid_o), 32'd0);
    start_i = 1'b0;

    run_burst(3'd0, 4'd8, 1'b0, 1'b0, 1'b1, 7'd56);  // table change after accept

    // Reset during beat 3 of a len=8 burst
    @(negedge clk);
    start_i     = 1'b1;
    start_idx_i = 3'd0;
    len_i       = 4'd8;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_idx", 32'(out_idx_o), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_sum", 32'(sum_o), 32'd0);
    chk("mid_rst_data", 32'(out_data_o), 32'd0);
    chk("mid_rst_idx", 32'(out_idx_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(3'd2, 4'd2, 1'b0, 1'b0, 1'b0, 7'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
